ni_inject_3port: RTL and testbench

Local-port network interface transmitter for the 2x4 mesh NoC. It packetizes core requests into 32-bit flits, writing a header whose destination field is data[2:0]. The router's route-compute stage decodes that field against the router address. Flits drive the router's local input port under credit-based flow control. This block is the injecting end of the flit format the router consumes.

---
 rtl/ni_inject_3port.sv | 188 ++++++++++++++++++
 tb/tb_ni_inject_3port.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_inject_3port.sv
// ni_inject_3port: local-port network interface transmitter.
// Packetizes core requests into 32-bit flits (head / body / tail / head+tail)
// and drives the router local input under credit-based flow control.
// Optional feature macro: NI_SEQ_EN adds an 8-bit packet sequence counter
// carried in header bits [17:10]; when undefined those bits are zero.
module ni_inject_3port #(
    parameter int unsigned CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  node_add_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_dest_i,
    input  logic [3:0]  req_len_i,
    input  logic        pl_valid_i,
    output logic        pl_ready_o,
    input  logic [29:0] pl_data_i,
    output logic        flit_valid_o,
    output logic [31:0] flit_data_o,
    input  logic        credit_in_i,
    output logic        err_self_o
);

    localparam logic [3:0] CreditsInit = 4'(CREDITS);

    localparam logic [1:0] TypeBody = 2'b00;
    localparam logic [1:0] TypeHead = 2'b01;
    localparam logic [1:0] TypeTail = 2'b10;
    localparam logic [1:0] TypeHt   = 2'b11;

    typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

    state_e      state_q, state_d;
    logic [3:0]  credit_q, credit_d;
    logic [3:0]  remaining_q, remaining_d;
    logic [2:0]  dest_q, dest_d;
    logic [3:0]  len_q, len_d;
    logic        flit_valid_q, flit_valid_d;
    logic [31:0] flit_data_q, flit_data_d;
    logic        err_self_q, err_self_d;
    logic [7:0]  seq_val;

    logic req_accept;
    logic req_self;
    logic credit_avail;
    logic send_head;
    logic send_body;
    logic flit_send;
    logic credit_inc;

    // Handshake and send qualifiers; all gated by the registered credit count
    // so a same-cycle credit_in never enables a send.
    assign req_accept   = req_valid_i && (state_q == StIdle);
    assign req_self     = (req_dest_i == node_add_i);
    assign credit_avail = (credit_q != 4'd0);
    assign send_head    = (state_q == StHead) && credit_avail;
    assign send_body    = (state_q == StBody) && credit_avail && pl_valid_i;
    assign flit_send    = send_head || send_body;

`ifdef NI_SEQ_EN
    logic [7:0] seq_q;

    // Packet sequence counter: advances once per emitted header, wraps at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= 8'd0;
        end else if (send_head) begin
            seq_q <= seq_q + 8'd1;
        end
    end

    assign seq_val = seq_q;
`else
    assign seq_val = 8'd0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: self-addressed requests are dropped without leaving IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_accept && !req_self) begin
                    state_d = StHead;
                end
            end
            StHead: begin
                if (credit_avail) begin
                    state_d = (len_q == 4'd0) ? StIdle : StBody;
                end
            end
            StBody: begin
                if (send_body && (remaining_q == 4'd1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: handshakes plus next values of the registered flit outputs
    // and the per-packet latches.
    always_comb begin
        req_ready_o  = (state_q == StIdle);
        pl_ready_o   = (state_q == StBody) && credit_avail;
        flit_valid_d = 1'b0;
        flit_data_d  = flit_data_q;
        err_self_d   = 1'b0;
        dest_d       = dest_q;
        len_d        = len_q;
        remaining_d  = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (req_accept) begin
                    if (req_self) begin
                        err_self_d = 1'b1;
                    end else begin
                        dest_d = req_dest_i;
                        len_d  = req_len_i;
                    end
                end
            end
            StHead: begin
                if (send_head) begin
                    flit_valid_d = 1'b1;
                    flit_data_d  = {(len_q == 4'd0) ? TypeHt : TypeHead, 12'd0, seq_val,
                                    len_q, node_add_i, dest_q};
                    remaining_d  = len_q;
                end
            end
            StBody: begin
                if (send_body) begin
                    flit_valid_d = 1'b1;
                    flit_data_d  = {(remaining_q == 4'd1) ? TypeTail : TypeBody, pl_data_i};
                    remaining_d  = remaining_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Credit counter next value: a send and an accepted credit cancel out;
    // credit_in at full count is ignored.
    always_comb begin
        credit_inc = credit_in_i && (credit_q != CreditsInit);
        credit_d   = credit_q;
        unique case ({flit_send, credit_inc})
            2'b10:   credit_d = credit_q - 4'd1;
            2'b01:   credit_d = credit_q + 4'd1;
            default: credit_d = credit_q;
        endcase
    end

    // Datapath registers: credits, packet latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q     <= CreditsInit;
            remaining_q  <= 4'd0;
            dest_q       <= 3'd0;
            len_q        <= 4'd0;
            flit_valid_q <= 1'b0;
            flit_data_q  <= 32'd0;
            err_self_q   <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            remaining_q  <= remaining_d;
            dest_q       <= dest_d;
            len_q        <= len_d;
            flit_valid_q <= flit_valid_d;
            flit_data_q  <= flit_data_d;
            err_self_q   <= err_self_d;
        end
    end

    assign flit_valid_o = flit_valid_q;
    assign flit_data_o  = flit_data_q;
    assign err_self_o   = err_self_q;

endmodule

// File: tb/tb_ni_inject_3port.sv
// Self-checking bench for ni_inject_3port (CREDITS = 4).
// Table of single-flit / self-addressed requests plus hand-written multi-flit,
// credit-stall, credit-corner, mid-packet reset and (NI_SEQ_EN) sequence runs.
// Expected flits are queued when stimulus is driven and compared on output.
module tb_ni_inject_3port;

    logic        clk;
    logic        rst_n;
    logic [2:0]  node_add;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_dest;
    logic [3:0]  req_len;
    logic        pl_valid;
    logic        pl_ready;
    logic [29:0] pl_data;
    logic        flit_valid;
    logic [31:0] flit_data;
    logic        credit_in;
    logic        err_self;

    ni_inject_3port #(.CREDITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .node_add_i   (node_add),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_dest_i   (req_dest),
        .req_len_i    (req_len),
        .pl_valid_i   (pl_valid),
        .pl_ready_o   (pl_ready),
        .pl_data_i    (pl_data),
        .flit_valid_o (flit_valid),
        .flit_data_o  (flit_data),
        .credit_in_i  (credit_in),
        .err_self_o   (err_self)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  node;
        logic [2:0]  dest;
        logic        self;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    int          total;
    int          bad;
    int          rx_count;
    int          rx0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge, score any flit seen there, then step
    // 1ns so stimulus changes stay clear of both edges.
    task automatic tick();
        @(negedge clk);
        if (flit_valid === 1'b1) begin
            rx_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_flit: got %h want none", flit_data);
            end else begin
                check("flit", flit_data, exp_q.pop_front());
            end
        end
        #1;
    endtask

    task automatic do_reset(input logic [2:0] node);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_dest  = 3'd0;
        req_len   = 4'd0;
        pl_valid  = 1'b0;
        pl_data   = 30'd0;
        credit_in = 1'b0;
        node_add  = node;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_req(input logic [2:0] dest, input logic [3:0] len);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_dest  = dest;
        req_len   = len;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got req_ready=0 want 1");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic feed(input logic [29:0] w);
        bit ok;
        ok       = 1'b0;
        pl_valid = 1'b1;
        pl_data  = w;
        for (int i = 0; i < 20; i++) begin
            if (pl_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL pl_timeout: got pl_ready=0 want 1");
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rx_count = 0;
        rst_n = 1'b0;
        node_add = 3'd0;
        req_valid = 1'b0;
        req_dest = 3'd0;
        req_len = 4'd0;
        pl_valid = 1'b0;
        pl_data = 30'd0;
        credit_in = 1'b0;

        vecs[0] = '{node: 3'd1, dest: 3'd6, self: 1'b0, exp: 32'hC000_000E};
        vecs[1] = '{node: 3'd3, dest: 3'd0, self: 1'b0, exp: 32'hC000_0018};
        vecs[2] = '{node: 3'd7, dest: 3'd5, self: 1'b0, exp: 32'hC000_003D};
        vecs[3] = '{node: 3'd0, dest: 3'd7, self: 1'b0, exp: 32'hC000_0007};
        vecs[4] = '{node: 3'd2, dest: 3'd2, self: 1'b1, exp: 32'h0000_0000};
        vecs[5] = '{node: 3'd5, dest: 3'd5, self: 1'b1, exp: 32'h0000_0000};

        // Reset state.
        do_reset(3'd1);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_pl_ready", 32'(pl_ready), 32'd0);
        check("rst_flit_valid", 32'(flit_valid), 32'd0);
        check("rst_flit_data", flit_data, 32'd0);
        check("rst_err_self", 32'(err_self), 32'd0);
        check("rst_credits", 32'(dut.credit_q), 32'd4);

        // Single-flit and self-addressed requests.
        for (int i = 0; i < 6; i++) begin
            do_reset(vecs[i].node);
            rx0 = rx_count;
            if (!vecs[i].self) exp_q.push_back(vecs[i].exp);
            send_req(vecs[i].dest, 4'd0);
            check("err_self", 32'(err_self), 32'(vecs[i].self));
            tick();
            check("err_self_pulse", 32'(err_self), 32'd0);
            check("flit_count", 32'(rx_count - rx0), vecs[i].self ? 32'd0 : 32'd1);
            check("credits_after", 32'(dut.credit_q), vecs[i].self ? 32'd4 : 32'd3);
            check("req_ready_after", 32'(req_ready), 32'd1);
            tick();
            check("flit_valid_strobe", 32'(flit_valid), 32'd0);
            check("flit_data_hold", flit_data, vecs[i].exp);
`ifdef NI_SEQ_EN
            check("seq_after", 32'(dut.seq_q), vecs[i].self ? 32'd0 : 32'd1);
`endif
        end

        // Head + body + tail, payload held valid.
        do_reset(3'd1);
        rx0 = rx_count;
        exp_q.push_back(32'h4000_008C);
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h8000_0002);
        send_req(3'd4, 4'd2);
        feed(30'h1);
        feed(30'h2);
        pl_valid = 1'b0;
        check("body_credits", 32'(dut.credit_q), 32'd1);
        check("body_req_ready", 32'(req_ready), 32'd1);
        tick();
        check("body_count", 32'(rx_count - rx0), 32'd3);

        // Credit starvation: stall, one credit gives exactly one body flit.
        do_reset(3'd1);
        rx0 = rx_count;
        exp_q.push_back(32'h4000_014A);
        exp_q.push_back(32'h0000_0011);
        exp_q.push_back(32'h0000_0012);
        exp_q.push_back(32'h0000_0013);
        exp_q.push_back(32'h0000_0014);
        exp_q.push_back(32'h8000_0015);
        send_req(3'd2, 4'd5);
        feed(30'h11);
        feed(30'h12);
        feed(30'h13);
        pl_data = 30'h14;
        tick();
        tick();
        tick();
        check("stall_pl_ready", 32'(pl_ready), 32'd0);
        check("stall_count", 32'(rx_count - rx0), 32'd4);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("credit_pl_ready", 32'(pl_ready), 32'd1);
        tick();
        pl_data = 30'h15;
        tick();
        tick();
        check("stall2_pl_ready", 32'(pl_ready), 32'd0);
        check("one_more_count", 32'(rx_count - rx0), 32'd5);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        tick();
        pl_valid = 1'b0;
        tick();
        check("tail_count", 32'(rx_count - rx0), 32'd6);
        check("tail_req_ready", 32'(req_ready), 32'd1);

        // Credit corners: send with credit_in at count 1; saturation at full.
        do_reset(3'd1);
        exp_q.push_back(32'h4000_00CB);
        exp_q.push_back(32'h0000_0021);
        exp_q.push_back(32'h0000_0022);
        exp_q.push_back(32'h8000_0023);
        send_req(3'd3, 4'd3);
        feed(30'h21);
        feed(30'h22);
        check("pre_concurrent_credits", 32'(dut.credit_q), 32'd1);
        pl_data = 30'h23;
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        pl_valid = 1'b0;
        check("concurrent_credits", 32'(dut.credit_q), 32'd1);
        credit_in = 1'b1;
        tick();
        tick();
        tick();
        check("refill_credits", 32'(dut.credit_q), 32'd4);
        tick();
        credit_in = 1'b0;
        check("saturate_credits", 32'(dut.credit_q), 32'd4);

        // Reset asserted mid-BODY: packet abandoned, no tail afterwards.
        do_reset(3'd1);
        exp_q.push_back(32'h4000_00CE);
        exp_q.push_back(32'h0000_0031);
        send_req(3'd6, 4'd3);
        feed(30'h31);
        pl_valid = 1'b0;
        rx0 = rx_count;
        rst_n = 1'b0;
        #1;
        check("midrst_flit_valid", 32'(flit_valid), 32'd0);
        check("midrst_flit_data", flit_data, 32'd0);
        check("midrst_credits", 32'(dut.credit_q), 32'd4);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_pl_ready", 32'(pl_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        pl_valid = 1'b1;
        tick();
        tick();
        tick();
        pl_valid = 1'b0;
        check("midrst_no_tail", 32'(rx_count - rx0), 32'd0);

`ifdef NI_SEQ_EN
        // 257 single-flit packets: sequence field runs 0..255 then wraps to 0.
        do_reset(3'd1);
        for (int k = 0; k < 257; k++) begin
            logic [7:0] s;
            s = 8'(k);
            exp_q.push_back({2'b11, 12'd0, s, 4'd0, 3'd1, 3'd6});
            send_req(3'd6, 4'd0);
            credit_in = 1'b1;
            tick();
            credit_in = 1'b0;
        end
        tick();
        check("seq_wrap", 32'(dut.seq_q), 32'd1);
`endif

        tick();
        check("queue_end", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
